// File: rtl/drac_pkg.sv
// Shared execute-stage types: functional unit encodings, sequencer states
// and the default watchdog sizing for multicycle units.
package drac_pkg;

  typedef enum logic [2:0] {
    UNIT_ALU    = 3'd0,
    UNIT_BRANCH = 3'd1,
    UNIT_MUL    = 3'd2,
    UNIT_DIV    = 3'd3,
    UNIT_MEM    = 3'd4
  } functional_unit_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_MUL = 2'd1,
    WAIT_DIV = 2'd2,
    WAIT_MEM = 2'd3
  } seq_state_t;

  // Longest a multicycle unit may stay outstanding, and a counter wide enough for it.
  localparam int SEQ_MAX_WAIT = 64;
  localparam int SEQ_CNT_W    = 7;

  // True for units that answer later with a done/ready pulse.
  function automatic logic is_multicycle(functional_unit_t fu);
    return (fu == UNIT_MUL) || (fu == UNIT_DIV) || (fu == UNIT_MEM);
  endfunction

endpackage

// File: rtl/exe_wait_counter.sv
// Watchdog for an outstanding multicycle operation: cleared on issue,
// counts while enabled, flags the last allowed cycle.
module exe_wait_counter #(
  parameter int MAX_WAIT = 64,
  parameter int CNT_W    = 7
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(MAX_WAIT - 1);

  logic [CNT_W-1:0] cnt;

  // Count wait cycles; clear takes priority so a fresh issue starts at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      cnt <= '0;
    else if (clear)  cnt <= '0;
    else if (enable) cnt <= cnt + 1'b1;
  end

  assign expire = (cnt == LAST);

endmodule

// File: rtl/exe_fu_sequencer.sv
// Execute-stage functional unit sequencer: single-cycle units write back
// immediately, multicycle units are issued once and waited on under a
// watchdog, with kill and timeout aborting the outstanding operation.
module exe_fu_sequencer
  import drac_pkg::*;
#(
  parameter int MAX_WAIT = SEQ_MAX_WAIT,
  parameter int CNT_W    = SEQ_CNT_W
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             instr_valid_i,
  input  functional_unit_t fu_i,
  input  logic [4:0]       rd_i,
  input  logic             kill_i,
  input  logic             mul_done_i,
  input  logic             div_done_i,
  input  logic             mem_ready_i,
  output logic             mul_req_o,
  output logic             div_req_o,
  output logic             mem_req_o,
  output logic             unit_kill_o,
  output logic             stall_o,
  output logic             wb_valid_o,
  output logic [4:0]       wb_rd_o,
  output functional_unit_t wb_sel_o,
  output logic             timeout_o
);

  seq_state_t       state_q, state_d;
  logic [4:0]       rd_q;
  functional_unit_t fu_q;
  logic             start;
  logic             waiting;
  logic             done_match;
  logic             expire;

  assign waiting = (state_q != IDLE);
  assign start   = (state_q == IDLE) && instr_valid_i && !kill_i && is_multicycle(fu_i);

  // Only the completion pulse of the unit being waited on counts.
  assign done_match = ((state_q == WAIT_MUL) && mul_done_i) ||
                      ((state_q == WAIT_DIV) && div_done_i) ||
                      ((state_q == WAIT_MEM) && mem_ready_i);

  exe_wait_counter #(
    .MAX_WAIT (MAX_WAIT),
    .CNT_W    (CNT_W)
  ) u_wdog (
    .clk    (clk_i),
    .rst_n  (rstn_i),
    .clear  (start),
    .enable (waiting),
    .expire (expire)
  );

  // State register.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Capture destination and unit of the instruction being issued.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      rd_q <= '0;
      fu_q <= UNIT_ALU;
    end else if (start) begin
      rd_q <= rd_i;
      fu_q <= fu_i;
    end
  end

  // Next state: issue moves to the matching wait, any termination returns to IDLE.
  always_comb begin
    state_d = state_q;
    if (state_q == IDLE) begin
      if (start) begin
        unique case (fu_i)
          UNIT_MUL: state_d = WAIT_MUL;
          UNIT_DIV: state_d = WAIT_DIV;
          default:  state_d = WAIT_MEM;
        endcase
      end
    end else if (kill_i || done_match || expire) begin
      state_d = IDLE;
    end
  end

  // Outputs: kill beats done, done beats timeout; reset silences everything at once.
  always_comb begin
    mul_req_o   = 1'b0;
    div_req_o   = 1'b0;
    mem_req_o   = 1'b0;
    unit_kill_o = 1'b0;
    stall_o     = 1'b0;
    wb_valid_o  = 1'b0;
    timeout_o   = 1'b0;
    wb_rd_o     = rd_q;
    wb_sel_o    = fu_q;
    if (!rstn_i) begin
      wb_rd_o  = '0;
      wb_sel_o = UNIT_ALU;
    end else if (kill_i) begin
      unit_kill_o = 1'b1;
    end else if (state_q == IDLE) begin
      if (instr_valid_i) begin
        case (fu_i)
          UNIT_ALU, UNIT_BRANCH: begin
            wb_valid_o = 1'b1;
            wb_rd_o    = rd_i;
            wb_sel_o   = fu_i;
          end
          UNIT_MUL: begin mul_req_o = 1'b1; stall_o = 1'b1; end
          UNIT_DIV: begin div_req_o = 1'b1; stall_o = 1'b1; end
          UNIT_MEM: begin mem_req_o = 1'b1; stall_o = 1'b1; end
          default: ;
        endcase
      end
    end else if (done_match) begin
      wb_valid_o = 1'b1;
    end else if (expire) begin
      timeout_o   = 1'b1;
      unit_kill_o = 1'b1;
    end else begin
      stall_o = 1'b1;
    end
  end

endmodule
